// File: rtl/operand_pair_loader_pkg.sv
// Shared types and sizing for the operand pair loader.
// Holds the FSM state encoding, the default operand width and the counter widths.
package operand_pair_loader_pkg;

    typedef enum logic [1:0] {
        WAIT_A = 2'd0,
        WAIT_B = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;
    localparam int PAIR_CNT_W    = 16;
    localparam int DROP_CNT_W    = 8;

endpackage

// File: rtl/operand_pair_loader_sat_counter.sv
// Saturating up-counter: increments on inc and sticks at its all-ones value.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && (cnt != {WIDTH{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/operand_pair_loader.sv
// Collects two operand bytes (A then B) from a byte stream and presents them as a pair.
// An in_sof byte arriving while B is awaited restarts the pair and counts as a drop.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   WAIT_A | idle, next accepted byte becomes op_a
//   WAIT_B | op_a held, next plain byte becomes op_b; sof byte replaces op_a
//   HOLD   | complete pair presented on pair_valid until the consumer takes it
module operand_pair_loader
    import operand_pair_loader_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      in_data,
    input  logic                  in_valid,
    input  logic                  in_sof,
    output logic                  in_ready,
    output logic [WIDTH-1:0]      op_a,
    output logic [WIDTH-1:0]      op_b,
    output logic                  pair_valid,
    input  logic                  pair_ready,
    output logic [PAIR_CNT_W-1:0] pair_cnt,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    state_t state_q;
    state_t state_d;
    logic   accept;
    logic   deliver;
    logic   load_a;
    logic   load_b;
    logic   drop_inc;
    logic   pair_inc;

    // While holding a pair, a new byte may only enter in the cycle the pair leaves.
    assign in_ready = (state_q != HOLD) || pair_ready;
    assign accept   = in_valid && in_ready;
    assign deliver  = pair_valid && pair_ready;

    always_comb begin
        state_d  = state_q;
        load_a   = 1'b0;
        load_b   = 1'b0;
        drop_inc = 1'b0;
        pair_inc = 1'b0;
        case (state_q)
            WAIT_A: begin
                if (accept) begin
                    load_a  = 1'b1;
                    state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                if (accept) begin
                    if (in_sof) begin
                        load_a   = 1'b1;
                        drop_inc = 1'b1;
                    end else begin
                        load_b  = 1'b1;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (deliver) begin
                    pair_inc = 1'b1;
                    if (accept) begin
                        load_a  = 1'b1;
                        state_d = WAIT_B;
                    end else begin
                        state_d = WAIT_A;
                    end
                end
            end
            default: state_d = WAIT_A;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= WAIT_A;
            op_a       <= '0;
            op_b       <= '0;
            pair_valid <= 1'b0;
            pair_cnt   <= '0;
        end else begin
            state_q    <= state_d;
            pair_valid <= (state_d == HOLD);
            if (load_a) op_a <= in_data;
            if (load_b) op_b <= in_data;
            if (pair_inc) pair_cnt <= pair_cnt + 1'b1;
        end
    end

    sat_counter #(
        .WIDTH(DROP_CNT_W)
    ) u_drop_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (drop_inc),
        .cnt  (drop_cnt)
    );

endmodule

// File: tb/tb_operand_pair_loader.sv
// Self-checking bench for operand_pair_loader: directed scenarios plus a scoreboard
// that checks every delivered pair against the pair expected from the stimulus.
module tb_operand_pair_loader;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_sof;
    logic        in_ready;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic        pair_valid;
    logic        pair_ready;
    logic [15:0] pair_cnt;
    logic [7:0]  drop_cnt;

    int checks = 0;
    int passes = 0;
    logic [15:0] sb_q[$];

    operand_pair_loader #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .pair_valid(pair_valid),
        .pair_ready(pair_ready),
        .pair_cnt  (pair_cnt),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every pair handed over must match the oldest expected pair.
    always @(negedge clk) begin
        if (rst_n && pair_valid && pair_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                $display("FAIL sb_unexpected: got a=%0d b=%0d, required no pair", op_a, op_b);
            end else begin
                automatic logic [15:0] exp = sb_q.pop_front();
                if ({op_a, op_b} !== exp)
                    $display("FAIL sb_pair: got a=%0d b=%0d, required a=%0d b=%0d",
                             op_a, op_b, exp[15:8], exp[7:0]);
                else
                    passes++;
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_sof     = 1'b0;
        in_data    = '0;
        pair_ready = 1'b0;
        sb_q.delete();
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    // Presents one byte and returns after the edge that accepted it; waited counts stall cycles.
    task automatic send_byte(input logic [7:0] d, input logic sof, output int waited);
        in_data  = d;
        in_sof   = sof;
        in_valid = 1'b1;
        waited   = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 50) begin
                checks++;
                $display("FAIL send_timeout: byte %0d not accepted within 50 cycles, required acceptance", d);
                break;
            end
        end
        cycle();
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) $display("FAIL %s: got %0d, required %0d", name, got, exp);
        else passes++;
    endtask

    task automatic test_reset();
        int w;
        apply_reset();
        pair_ready = 1'b1;
        send_byte(8'd99, 1'b1, w);
        idle();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, pair_valid, op_a, op_b, pair_cnt, drop_cnt} !== {1'b1, 1'b0, 40'd0})
            $display("FAIL reset_state: got rdy=%0b pv=%0b a=%0d b=%0d pc=%0d dc=%0d, required 1 0 0 0 0 0",
                     in_ready, pair_valid, op_a, op_b, pair_cnt, drop_cnt);
        else
            passes++;
        apply_reset();
        check("reset_ready_after", in_ready, 1);
    endtask

    task automatic test_single_pair();
        int w;
        apply_reset();
        pair_ready = 1'b1;
        sb_q.push_back({8'd10, 8'd5});
        send_byte(8'd10, 1'b1, w);
        send_byte(8'd5, 1'b0, w);
        idle();
        check("single_pv_latency", pair_valid, 1);
        check("single_op_a", op_a, 10);
        check("single_op_b", op_b, 5);
        cycle();
        check("single_pv_one_cycle", pair_valid, 0);
        check("single_pair_cnt", pair_cnt, 1);
    endtask

    task automatic test_stall();
        int w;
        apply_reset();
        pair_ready = 1'b0;
        sb_q.push_back({8'd10, 8'd5});
        send_byte(8'd10, 1'b1, w);
        send_byte(8'd5, 1'b0, w);
        in_data  = 8'd77;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({pair_valid, in_ready, op_a, op_b} !== {1'b1, 1'b0, 8'd10, 8'd5})
                $display("FAIL stall_hold[%0d]: got pv=%0b rdy=%0b a=%0d b=%0d, required 1 0 10 5",
                         i, pair_valid, in_ready, op_a, op_b);
            else
                passes++;
        end
        idle();
        @(posedge clk);
        #1;
        pair_ready = 1'b1;
        check("stall_pair_cnt_before", pair_cnt, 0);
        cycle();
        check("stall_pair_cnt", pair_cnt, 1);
        check("stall_pv_cleared", pair_valid, 0);
        // One plain byte from WAIT_A only fills op_a; no pair may appear.
        send_byte(8'd33, 1'b0, w);
        idle();
        check("stall_back_to_wait_a_op_a", op_a, 33);
        check("stall_back_to_wait_a_pv", pair_valid, 0);
    endtask

    task automatic test_resync();
        int w;
        apply_reset();
        pair_ready = 1'b1;
        sb_q.push_back({8'd9, 8'd3});
        send_byte(8'd7, 1'b1, w);
        send_byte(8'd9, 1'b1, w);
        check("resync_drop_early", drop_cnt, 1);
        send_byte(8'd3, 1'b0, w);
        idle();
        check("resync_op_a", op_a, 9);
        check("resync_op_b", op_b, 3);
        cycle();
        check("resync_drop_cnt", drop_cnt, 1);
        check("resync_pair_cnt", pair_cnt, 1);
    endtask

    task automatic test_back_to_back();
        int w;
        int stalls;
        apply_reset();
        pair_ready = 1'b1;
        stalls = 0;
        for (int p = 0; p < 3; p++) begin
            sb_q.push_back({8'(2 * p + 1), 8'(2 * p + 2)});
            send_byte(8'(2 * p + 1), 1'b1, w);
            stalls += w;
            send_byte(8'(2 * p + 2), 1'b0, w);
            stalls += w;
            checks++;
            if (pair_valid !== 1'b1 || op_a !== 8'(2 * p + 1) || op_b !== 8'(2 * p + 2))
                $display("FAIL b2b_pair[%0d]: got pv=%0b a=%0d b=%0d, required 1 %0d %0d",
                         p, pair_valid, op_a, op_b, 2 * p + 1, 2 * p + 2);
            else
                passes++;
        end
        idle();
        check("b2b_no_stalls", stalls, 0);
        cycle();
        check("b2b_pair_cnt", pair_cnt, 3);
    endtask

    task automatic test_reset_mid_pair();
        int w;
        apply_reset();
        pair_ready = 1'b1;
        send_byte(8'd20, 1'b1, w);
        idle();
        check("midrst_op_a_loaded", op_a, 20);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({op_a, op_b, pair_valid, in_ready} !== {8'd0, 8'd0, 1'b0, 1'b1})
            $display("FAIL midrst_async: got a=%0d b=%0d pv=%0b rdy=%0b, required 0 0 0 1",
                     op_a, op_b, pair_valid, in_ready);
        else
            passes++;
        cycle();
        rst_n = 1'b1;
        sb_q.push_back({8'd4, 8'd6});
        send_byte(8'd4, 1'b0, w);
        send_byte(8'd6, 1'b0, w);
        idle();
        check("midrst_op_a", op_a, 4);
        check("midrst_op_b", op_b, 6);
        cycle();
        check("midrst_drop_cnt", drop_cnt, 0);
        check("midrst_pair_cnt", pair_cnt, 1);
    endtask

    task automatic test_pair_cnt_wrap();
        int w;
        apply_reset();
        pair_ready = 1'b1;
        for (int i = 0; i < 65537; i++) begin
            sb_q.push_back({8'(i), 8'(i + 7)});
            send_byte(8'(i), 1'b1, w);
            send_byte(8'(i + 7), 1'b0, w);
            if (i == 65534) begin
                cycle();
                idle();
                check("wrap_pair_cnt_ffff", pair_cnt, 16'hFFFF);
            end
        end
        idle();
        cycle();
        check("wrap_pair_cnt", pair_cnt, 1);
    endtask

    task automatic test_drop_saturate();
        int w;
        apply_reset();
        pair_ready = 1'b1;
        send_byte(8'd0, 1'b1, w);
        for (int i = 1; i <= 300; i++) begin
            send_byte(8'(i), 1'b1, w);
            if (i == 254) check("drop_cnt_254", drop_cnt, 254);
        end
        check("drop_cnt_sat", drop_cnt, 255);
        sb_q.push_back({8'(300), 8'd55});
        send_byte(8'd55, 1'b0, w);
        idle();
        cycle();
        check("drop_cnt_sat_hold", drop_cnt, 255);
        check("drop_pair_cnt", pair_cnt, 1);
    endtask

    initial begin
        rst_n      = 1'b0;
        in_data    = '0;
        in_valid   = 1'b0;
        in_sof     = 1'b0;
        pair_ready = 1'b0;
        test_reset();
        test_single_pair();
        test_stall();
        test_resync();
        test_back_to_back();
        test_reset_mid_pair();
        test_drop_saturate();
        test_pair_cnt_wrap();
        check("sb_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
